// File: rtl/seq_det_param.sv
// Parametrised Mealy serial-pattern detector with a runtime-loadable pattern and length.
// Optional macro SEQ_DET_REG_OUT_EN registers the match output (one cycle later).
module seq_det_param #(
  parameter int                   MAX_LEN     = 8,
  parameter int                   LEN_W       = 4,
  parameter int                   CNT_W       = 8,
  parameter logic [MAX_LEN-1:0]   DEF_PATTERN = MAX_LEN'(8'b0000_1101),
  parameter logic [LEN_W-1:0]     DEF_LEN     = LEN_W'(4),
  parameter logic                 DEF_OVERLAP = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din_valid,
  input  logic               din,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               count_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  localparam logic [LEN_W-1:0] MAX_FILL = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] pattern;
  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   fill;
  logic               overlap;
  logic               eq;
  logic               fill_ok;
  logic               hit;

  always_comb begin
    window = {hist[MAX_LEN-2:0], din};
    mask   = '0;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (i < int'(len));
    eq      = ((window ^ pattern) & mask) == '0;
    // fill >= len-1, written as fill+1 >= len so len=0 cannot underflow
    fill_ok = ({1'b0, fill} + (LEN_W+1)'(1)) >= {1'b0, len};
    // NOTE: gating with rst keeps match low throughout reset, whatever the default length.
    hit     = rst & din_valid & ~cfg_load & ~cfg_err & fill_ok & eq;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern <= DEF_PATTERN;
      len     <= DEF_LEN;
      overlap <= DEF_OVERLAP;
      hist    <= '0;
      fill    <= '0;
      cfg_err <= 1'b0;
    end else if (cfg_load) begin
      pattern <= cfg_pattern;
      len     <= cfg_len;
      overlap <= cfg_overlap;
      hist    <= '0;
      fill    <= '0;
      cfg_err <= (cfg_len == '0) || (cfg_len > MAX_FILL);
    end else if (din_valid) begin
      hist <= window;
      if (hit && !overlap)
        fill <= '0;
      else if (fill != MAX_FILL)
        fill <= fill + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      match_count <= '0;
    else if (count_clr || cfg_load)
      match_count <= '0;
    else if (hit && (match_count != '1))
      match_count <= match_count + CNT_W'(1);
  end

`ifdef SEQ_DET_REG_OUT_EN
  logic match_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      match_q <= 1'b0;
    else if (cfg_load)
      match_q <= 1'b0;
    else
      match_q <= hit;
  end

  assign match = match_q;
`else
  assign match = hit;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Directed self-checking bench for seq_det_param; a second instance with CNT_W=2 covers saturation.
// Works with or without SEQ_DET_REG_OUT_EN (match sampled before or after the edge accordingly).
module tb_seq_det_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       din_valid = 1'b0;
  logic       din = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       count_clr = 1'b0;

  logic       match_a, err_a, match_b, err_b;
  logic [7:0] count_a;
  logic [1:0] count_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_det_param dut_a (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .count_clr(count_clr), .match(match_a), .match_count(count_a), .cfg_err(err_a)
  );

  seq_det_param #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .count_clr(count_clr), .match(match_b), .match_count(count_b), .cfg_err(err_b)
  );

  // One clock of stimulus; returns match as seen for the bit driven in this cycle.
  task automatic step(input logic v, input logic d, input logic clr,
                      output logic ma, output logic mb);
    @(negedge clk);
    din_valid = v;
    din       = d;
    count_clr = clr;
    cfg_load  = 1'b0;
    #1;
    ma = match_a;
    mb = match_b;
    @(posedge clk);
    #1;
`ifdef SEQ_DET_REG_OUT_EN
    ma = match_a;
    mb = match_b;
`endif
    din_valid = 1'b0;
    count_clr = 1'b0;
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ov);
    @(negedge clk);
    cfg_load    = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ov;
    din_valid   = 1'b1;
    din         = 1'b1;
    @(posedge clk);
    #1;
    cfg_load  = 1'b0;
    din_valid = 1'b0;
  endtask

  task automatic test_reset();
    din_valid = 1'b1;
    din       = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (match_a !== 1'b0) begin n_fail++; $display("FAIL reset_match: got %b want 0", match_a); end
    n_checks++;
    if (count_a !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count_a); end
    n_checks++;
    if (err_a !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_a); end
    din_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_default_overlap();
    logic s [7] = '{1, 1, 0, 1, 1, 0, 1};
    logic e [7] = '{0, 0, 0, 1, 0, 0, 1};
    logic ma, mb;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, s[i], 1'b0, ma, mb);
      n_checks++;
      if (ma !== e[i]) begin n_fail++; $display("FAIL default_overlap bit%0d: match=%b want %b", i + 1, ma, e[i]); end
    end
    n_checks++;
    if (count_a !== 8'd2) begin n_fail++; $display("FAIL default_overlap_count: got %0d want 2", count_a); end
  endtask

  task automatic test_non_overlap();
    logic s [7] = '{1, 1, 0, 1, 1, 0, 1};
    logic e [7] = '{0, 0, 0, 1, 0, 0, 0};
    logic ma, mb;
    load(8'h0D, 4'd4, 1'b0);
    n_checks++;
    if (count_a !== 8'd0) begin n_fail++; $display("FAIL load_clears_count: got %0d want 0", count_a); end
    for (int i = 0; i < 7; i++) begin
      step(1'b1, s[i], 1'b0, ma, mb);
      n_checks++;
      if (ma !== e[i]) begin n_fail++; $display("FAIL non_overlap bit%0d: match=%b want %b", i + 1, ma, e[i]); end
    end
    n_checks++;
    if (count_a !== 8'd1) begin n_fail++; $display("FAIL non_overlap_count: got %0d want 1", count_a); end
  endtask

  task automatic test_gaps();
    logic v [13] = '{1, 0, 1, 1, 0, 0, 1, 1, 0, 1, 1, 0, 1};
    logic d [13] = '{1, 1, 0, 1, 0, 1, 0, 0, 1, 1, 1, 0, 1};
    logic ma, mb, exp_m;
    load(8'b1010_0111, 4'd8, 1'b1);
    for (int i = 0; i < 13; i++) begin
      step(v[i], d[i], 1'b0, ma, mb);
      exp_m = (i == 12);
      n_checks++;
      if (ma !== exp_m) begin n_fail++; $display("FAIL gaps cycle%0d: match=%b want %b", i, ma, exp_m); end
    end
    n_checks++;
    if (count_a !== 8'd1) begin n_fail++; $display("FAIL gaps_count: got %0d want 1", count_a); end
  endtask

  task automatic test_cfg_err();
    logic s [10] = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 1};
    logic ma, mb, exp_m;
    load(8'h0D, 4'd0, 1'b1);
    n_checks++;
    if (err_a !== 1'b1) begin n_fail++; $display("FAIL err_len0: got %b want 1", err_a); end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, s[i], 1'b0, ma, mb);
      n_checks++;
      if (ma !== 1'b0) begin n_fail++; $display("FAIL err_len0_match bit%0d: got %b want 0", i + 1, ma); end
    end
    load(8'h0D, 4'd9, 1'b1);
    n_checks++;
    if (err_a !== 1'b1) begin n_fail++; $display("FAIL err_len9: got %b want 1", err_a); end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, s[i], 1'b0, ma, mb);
      n_checks++;
      if (ma !== 1'b0) begin n_fail++; $display("FAIL err_len9_match bit%0d: got %b want 0", i + 1, ma); end
    end
    n_checks++;
    if (count_a !== 8'd0) begin n_fail++; $display("FAIL err_count: got %0d want 0", count_a); end
    load(8'h0D, 4'd4, 1'b1);
    n_checks++;
    if (err_a !== 1'b0) begin n_fail++; $display("FAIL err_recover: got %b want 0", err_a); end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, s[i], 1'b0, ma, mb);
      exp_m = (i == 3);
      n_checks++;
      if (ma !== exp_m) begin n_fail++; $display("FAIL err_resume bit%0d: match=%b want %b", i + 1, ma, exp_m); end
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_b [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    logic ma, mb;
    load(8'h01, 4'd1, 1'b1);
    step(1'b1, 1'b0, 1'b0, ma, mb);
    n_checks++;
    if (mb !== 1'b0) begin n_fail++; $display("FAIL len1_zero: match=%b want 0", mb); end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, ma, mb);
      n_checks++;
      if (mb !== 1'b1) begin n_fail++; $display("FAIL len1_match bit%0d: got %b want 1", i + 1, mb); end
      n_checks++;
      if (count_b !== exp_b[i]) begin n_fail++; $display("FAIL sat_count bit%0d: got %0d want %0d", i + 1, count_b, exp_b[i]); end
    end
    n_checks++;
    if (count_a !== 8'd6) begin n_fail++; $display("FAIL wide_count: got %0d want 6", count_a); end
    step(1'b1, 1'b1, 1'b1, ma, mb);
    n_checks++;
    if (mb !== 1'b1) begin n_fail++; $display("FAIL clr_match: got %b want 1", mb); end
    n_checks++;
    if (count_b !== 2'd0) begin n_fail++; $display("FAIL clr_wins: got %0d want 0", count_b); end
    step(1'b1, 1'b1, 1'b0, ma, mb);
    n_checks++;
    if (count_b !== 2'd1) begin n_fail++; $display("FAIL after_clr: got %0d want 1", count_b); end
  endtask

  task automatic test_reset_mid();
    logic pre [7] = '{1, 1, 0, 1, 1, 1, 0};
    logic s [5]   = '{1, 1, 1, 0, 1};
    logic e [5]   = '{0, 0, 0, 0, 1};
    logic ma, mb;
    load(8'h0B, 4'd4, 1'b0);
    load(8'h0D, 4'd4, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, pre[i], 1'b0, ma, mb);
    n_checks++;
    if (count_a !== 8'd1) begin n_fail++; $display("FAIL pre_reset_count: got %0d want 1", count_a); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (count_a !== 8'd0) begin n_fail++; $display("FAIL mid_reset_count: got %0d want 0", count_a); end
    n_checks++;
    if (match_a !== 1'b0) begin n_fail++; $display("FAIL mid_reset_match: got %b want 0", match_a); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, s[i], 1'b0, ma, mb);
      n_checks++;
      if (ma !== e[i]) begin n_fail++; $display("FAIL reset_mid bit%0d: match=%b want %b", i + 1, ma, e[i]); end
    end
    n_checks++;
    if (count_a !== 8'd1) begin n_fail++; $display("FAIL reset_mid_count: got %0d want 1", count_a); end
  endtask

  initial begin
    test_reset();
    test_default_overlap();
    test_non_overlap();
    test_gaps();
    test_cfg_err();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_det_param.md
Name: seq_det_param

Overview:
- Parametrised Mealy serial-pattern detector; successor to the fixed 4-bit overlapping detector family.
- Runtime-loadable pattern and length up to MAX_LEN bits, overlapping or non-overlapping mode, input qualifier, and a saturating match counter.
- Sits on a serial bit stream, e.g. after a deserialiser or line decoder, and flags frame or sync words to downstream control logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- LEN_W, 4, width of cfg_len; must hold MAX_LEN (>= clog2(MAX_LEN+1)).
- CNT_W, 8, width of match_count.
- DEF_PATTERN, 8'b0000_1101, pattern after reset (LSB-aligned).
- DEF_LEN, 4, pattern length after reset.
- DEF_OVERLAP, 1, overlap mode after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- din_valid  in  1  din is sampled this cycle.
- din  in  1  serial data bit.
- cfg_load  in  1  load cfg_* this cycle.
- cfg_pattern  in  MAX_LEN  new pattern, LSB-aligned; bit len-1 is the first bit received.
- cfg_len  in  LEN_W  new pattern length.
- cfg_overlap  in  1  1 = overlapping, 0 = non-overlapping.
- count_clr  in  1  synchronous clear of match_count.
- match  out  1  Mealy match flag, combinational from current din.
- match_count  out  CNT_W  number of matches, saturating.
- cfg_err  out  1  loaded length is invalid; detection is disabled.

Behaviour:
- Reset (rst=0, asynchronous): pattern=DEF_PATTERN, len=DEF_LEN, overlap=DEF_OVERLAP, hist=0, fill=0, match_count=0, cfg_err=0. match=0 while in reset.
- State:
  - hist[MAX_LEN-1:0]: shift register of past bits; the newest bit is the LSB.
  - fill: 0..MAX_LEN, number of valid history bits, saturating at MAX_LEN.
- Window: the low len bits of {hist, din}, oldest bit at the MSB.
- match = din_valid & ~cfg_load & ~cfg_err & (fill >= len-1) & (window == pattern[len-1:0]).
  - Same-cycle (Mealy) output, 0 cycles latency from the final pattern bit.
- Accepted bit (din_valid=1, cfg_load=0):
  - hist <= {hist[MAX_LEN-2:0], din}; fill <= min(fill+1, MAX_LEN).
  - If match and overlap=0: fill <= 0 instead, so the next match needs len fresh bits.
  - If match and overlap=1: fill continues, so a pattern suffix can start the next match.
- din_valid=0: hist, fill and match_count hold; match=0.
- cfg_load=1 (takes priority over din):
  - Latch cfg_pattern, cfg_len and cfg_overlap; clear hist, fill and match_count; the din bit in that cycle is discarded.
  - cfg_err <= (cfg_len < 1) | (cfg_len > MAX_LEN).
  - cfg_err stays set until the next valid load or reset; while it is set, match=0 and match_count does not advance.
- len=1: fill>=0 always holds, so every valid din equal to pattern[0] matches.
- match_count:
  - Increments by 1 on each match; saturates at 2^CNT_W-1 (no wrap).
  - count_clr=1 forces 0 that cycle; clear wins over a simultaneous increment.
  - cfg_load also clears the counter.
- Reset mid-stream discards all partial progress; detection restarts with fill=0.

Optional Feature:
- Macro: SEQ_DET_REG_OUT_EN.
- Defined: match is registered, a Moore-style output asserted exactly 1 cycle after the final pattern bit and high for 1 cycle. The internal hit still drives fill and match_count in the cycle of the final bit. The register resets to 0 and is cleared by cfg_load.
- Undefined: match is combinational as above.

Test Plan:
- Defaults (1101, overlap): valid stream 1,1,0,1,1,0,1 -> match high on bits 4 and 7; match_count=2.
- Load pattern 1101, len 4, overlap=0; stream 1,1,0,1,1,0,1 -> match only on bit 4; match_count=1.
- Load pattern 8'b1010_0111, len 8; stream with din_valid gaps inside the pattern -> single match on the 8th valid bit; no match in any cycle where din_valid=0.
- CNT_W=2, len 1, pattern 1; six valid 1s -> match_count 1,2,3,3,3,3. count_clr together with a match -> 0.
- Load cfg_len=0, then cfg_len=MAX_LEN+1 -> cfg_err=1 and no match on any stream. A subsequent load with len 4 -> cfg_err=0 and detection resumes.
- rst pulsed low after 3 bits of 1101 -> next bit 1 gives no match; full 1,1,0,1 afterwards gives a match. With SEQ_DET_REG_OUT_EN defined, every case above shows match delayed by exactly 1 cycle.
